// File: rtl/text_console.sv
// Text-mode console feeder: turns a byte stream into char/attr writes in the
// 80x25 video RAM, with cursor tracking, newline, backspace, clear and scroll-up.
module text_console #(
    parameter int          COLS      = 80,
    parameter int          ROWS      = 25,
    parameter logic [7:0]  FILL_CHAR = 8'h20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic [7:0]  in_attr,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [11:0] mem_address,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic [10:0] cursor,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    // Handshake: a byte transfers on a rising clock edge where in_valid and
    // in_ready are both high; in_ready is high only in IDLE, and the source
    // must hold in_data/in_attr stable until that edge.

    localparam int          CELLS         = COLS * ROWS;
    localparam logic [11:0] LAST_BYTE     = 12'(2 * CELLS - 1);
    localparam logic [11:0] ROW_BYTES     = 12'(2 * COLS);
    localparam logic [11:0] LAST_ROW_BYTE = 12'(2 * (CELLS - COLS));
    localparam logic [4:0]  LAST_ROW      = 5'(ROWS - 1);
    localparam logic [6:0]  LAST_COL      = 7'(COLS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_CHAR = 3'd1,
        WR_ATTR = 3'd2,
        SCR_RD  = 3'd3,
        SCR_WR  = 3'd4,
        FILL_CH = 3'd5,
        FILL_AT = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  row_q, row_d;
    logic [6:0]  col_q, col_d;
    logic [10:0] cursor_q, cursor_d;
    logic [7:0]  attr_q, attr_d;
    logic [7:0]  char_q, char_d;
    logic [11:0] addr_q, addr_d;
    logic        clr_q, clr_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            cursor_q <= '0;
            attr_q   <= '0;
            char_q   <= '0;
            addr_q   <= '0;
            clr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            cursor_q <= cursor_d;
            attr_q   <= attr_d;
            char_q   <= char_d;
            addr_q   <= addr_d;
            clr_q    <= clr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        attr_d      = attr_q;
        char_d      = char_q;
        addr_d      = addr_q;
        clr_d       = clr_q;
        mem_we      = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    attr_d = in_attr;
                    char_d = in_data;
                    case (in_data)
                        8'h0D: col_d = '0;
                        8'h0A: begin
                            // At the last row the cursor stays put until the scroll completes.
                            if (row_q == LAST_ROW) begin
                                state_d = SCR_RD;
                                addr_d  = ROW_BYTES;
                                clr_d   = 1'b0;
                            end else begin
                                col_d = '0;
                                row_d = row_q + 5'd1;
                            end
                        end
                        8'h08: begin
                            if (col_q != '0) begin
                                col_d = col_q - 7'd1;
                            end else if (row_q != '0) begin
                                row_d = row_q - 5'd1;
                                col_d = LAST_COL;
                            end
                        end
                        8'h0C: begin
                            state_d = FILL_CH;
                            addr_d  = '0;
                            clr_d   = 1'b1;
                        end
                        default: state_d = WR_CHAR;
                    endcase
                end
            end
            WR_CHAR: begin
                mem_we      = 1'b1;
                mem_address = {cursor_q, 1'b0};
                mem_wdata   = char_q;
                state_d     = WR_ATTR;
            end
            WR_ATTR: begin
                mem_we      = 1'b1;
                mem_address = {cursor_q, 1'b1};
                mem_wdata   = attr_q;
                state_d     = IDLE;
                if (col_q == LAST_COL) begin
                    if (row_q == LAST_ROW) begin
                        state_d = SCR_RD;
                        addr_d  = ROW_BYTES;
                        clr_d   = 1'b0;
                    end else begin
                        col_d = '0;
                        row_d = row_q + 5'd1;
                    end
                end else begin
                    col_d = col_q + 7'd1;
                end
            end
            SCR_RD: begin
                mem_address = addr_q;
                state_d     = SCR_WR;
            end
            SCR_WR: begin
                // Read data for addr_q arrives now; it lands one row lower.
                mem_we      = 1'b1;
                mem_address = addr_q - ROW_BYTES;
                mem_wdata   = mem_rdata;
                if (addr_q == LAST_BYTE) begin
                    state_d = FILL_CH;
                    addr_d  = LAST_ROW_BYTE;
                end else begin
                    state_d = SCR_RD;
                    addr_d  = addr_q + 12'd1;
                end
            end
            FILL_CH: begin
                mem_we      = 1'b1;
                mem_address = addr_q;
                mem_wdata   = FILL_CHAR;
                addr_d      = addr_q + 12'd1;
                state_d     = FILL_AT;
            end
            FILL_AT: begin
                mem_we      = 1'b1;
                mem_address = addr_q;
                mem_wdata   = attr_q;
                if (addr_q == LAST_BYTE) begin
                    state_d = IDLE;
                    col_d   = '0;
                    row_d   = clr_q ? 5'd0 : LAST_ROW;
                end else begin
                    addr_d  = addr_q + 12'd1;
                    state_d = FILL_CH;
                end
            end
            default: state_d = IDLE;
        endcase
        cursor_d = 11'(row_d) * 11'(COLS) + 11'(col_d);
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = ~in_ready;
    assign cursor    = cursor_q;
    assign state_dbg = state_q;

endmodule

// File: doc/text_console.md
# text_console

Upstream feeder of the text-mode display adapter. Accepts a byte stream (printable characters plus a few control codes) over a valid/ready handshake. Writes character/attribute pairs into the shared 4000-byte video RAM that the adapter scans, handling cursor advance, newline, backspace, clear-screen and one-line scroll-up. Drives the 11-bit linear cursor position that the adapter uses to draw the blinking underline.

## Interface
Parameters:
- COLS, 80, characters per row
- ROWS, 25, rows per screen
- FILL_CHAR, 8'h20, character code written by clear and scroll fill

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  system clock (25 MHz domain shared with the display adapter)
- reset  in  1  synchronous, active-high
- in_data  in  8  byte to print or control code
- in_attr  in  8  attribute for this byte (bit7 blink, [6:4] background, [3:0] foreground)
- in_valid  in  1  in_data/in_attr valid
- in_ready  out  1  block idle, byte accepted when in_valid & in_ready
- mem_address  out  12  video RAM byte address
- mem_wdata  out  8  write data
- mem_we  out  1  write strobe
- mem_rdata  in  8  read data, valid one cycle after mem_address (synchronous RAM)
- cursor  out  11  linear cursor cell 0..COLS*ROWS-1
- busy  out  1  ~in_ready

## Operation
- Memory layout: cell id = row*COLS+col. Character at byte {id,1'b0}, attribute at byte {id,1'b1}.
- Internal registers: row (0..ROWS-1), col (0..COLS-1), latched attr. cursor = row*COLS+col, registered, updated together with row/col.
- Byte decode on acceptance:
  - 0x0D CR: col=0, no memory access.
  - 0x0A LF: col=0, row+1. If row was ROWS-1, perform SCROLL and keep row=ROWS-1.
  - 0x08 BS: if col>0 then col-1, else if row>0 then row-1, col=COLS-1, else no change. Nothing is erased.
  - 0x0C FF: CLEAR writes FILL_CHAR/attr to all cells, then row=col=0.
  - Any other value: write char then attr at cursor, then advance col. At col=COLS-1, col=0 and row+1. At the last cell (1999), perform SCROLL; afterwards row=ROWS-1, col=0 (cursor=1920).
- SCROLL: copy bytes 2*COLS..3999 down to 0..3999-2*COLS, ascending, one byte per read/write pair. Then fill the last row with FILL_CHAR/attr.
- States: IDLE, WR_CHAR, WR_ATTR, SCR_RD, SCR_WR, FILL_CH, FILL_AT.
  - IDLE -> WR_CHAR on printable byte.
  - IDLE -> FILL_CH on FF (range 0..1999).
  - IDLE -> SCR_RD on LF at the last row.
  - IDLE stays on CR/BS.
  - WR_CHAR -> WR_ATTR.
  - WR_ATTR -> IDLE, or -> SCR_RD on wrap past the last cell.
  - SCR_RD <-> SCR_WR until source 3999 is copied, then -> FILL_CH (range 1920..1999).
  - FILL_CH <-> FILL_AT until the range end, then -> IDLE.
- The attr used by fills is in_attr latched at the accepting handshake.

## Timing
- Reset: state=IDLE, row=col=0, cursor=0, mem_we=0, mem_address=0, mem_wdata=0. in_ready=1 from the first cycle after reset deasserts. Video RAM is not cleared.
- Reset mid-operation (scroll/clear) aborts at once: mem_we=0 in the next cycle, memory is left partially updated, cursor=0.
- in_ready=1 only in IDLE. The accept cycle performs no memory write.
- Printable byte: accept at cycle T, char write at T+1 (mem_we=1), attr write at T+2. cursor updates at T+3, with in_ready=1 at T+3.
- CR/BS/LF (no scroll): cursor updates at T+1, in_ready stays 1.
- SCR_RD drives mem_address=src with mem_we=0. SCR_WR drives mem_address=src-2*COLS, mem_wdata=mem_rdata, mem_we=1.
- Scroll costs 2*3840 copy cycles plus 160 fill cycles. Clear costs 4000 cycles. cursor changes only when the operation finishes.
- in_valid while busy is ignored (not consumed). The byte is held by the source.

## Test plan
- Reset, then bytes 'A'(0x41, attr 0x1F), 'B'(0x42, attr 0x1F): writes 0x41@0, 0x1F@1, 0x42@2, 0x1F@3; cursor=2; exactly 3 cycles per byte from accept to in_ready.
- Place cursor at col 5 on row 3, send CR, then LF: cursor 245 -> 240 -> 320, no mem_we pulses.
- BS at cursor 0: cursor stays 0. BS at cursor 80: cursor=79.
- Preload RAM with pattern byte[a]=a[7:0], set cursor to 1999, send 'Z'(attr 0x07):
  - 'Z' lands at 3998/3999 before the scroll; after the scroll byte[a]=pattern(a+160) for a<3840, which places Z/0x07 at 3838/3839 (cell 1919).
  - Last row filled 0x20/0x07, cursor=1920.
  - busy lasts 7840 cycles after the attr write.
- FF with attr 0x1E: all 2000 cells = 0x20/0x1E, cursor=0, busy for 4000 cycles.
- Assert reset at cycle 100 of a scroll: mem_we=0 the next cycle, cursor=0, in_ready=1 after release; a following 'A' writes at address 0.
